// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory access scheduler.
//   state_e : controller FSM states
//   OP_*    : cell-array operation encoding driven on mem_op
package mem_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        WAIT,
        RESP,
        RECOVER
    } state_e;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter (purely combinational).
//   req   : request vector
//   last  : index of the requester granted most recently
//   grant : one-hot grant, or zero when nothing is requested
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            // On contention the requester that did not win last time goes first.
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_access_scheduler.sv
// Two-port scheduler in front of a single cell array. Grants one requester at
// a time, sequences SETUP/ACCESS/WAIT on the array, returns a one-cycle ack
// (with err on timeout) and then parks the array for two RECOVER cycles.
//   clk, rst_n           : clock, asynchronous active-low reset
//   req, we, addr, wdata : per-requester request, packed [i*W +: W]
//   ack, err, rdata      : per-requester completion pulse, timeout flag, read data
//   mem_select, mem_op   : cell-array select and operation
//   mem_addr, mem_wdata  : latched address / write data of the granted request
//   mem_rdata, mem_valid : cell-array read data and completion strobe
module mem_access_scheduler
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          req,
    input  logic [1:0]          we,
    input  logic [2*ADDR_W-1:0] addr,
    input  logic [2*DATA_W-1:0] wdata,
    output logic [1:0]          ack,
    output logic                err,
    output logic [DATA_W-1:0]   rdata,
    output logic                mem_select,
    output logic                mem_op,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_valid
);

    localparam int                CNT_W    = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rec_q, rec_d;
    logic               timeout_hit;

    logic [1:0]         grant;
    logic               new_idx;
    logic               last_q;
    logic               we_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic [DATA_W-1:0]  mem_wdata_q;

    logic [1:0]         ack_q, ack_d;
    logic               err_q, err_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               mem_select_q, mem_select_d;
    logic               mem_op_q, mem_op_d;

    rr_arb2 u_arb (
        .req   (req),
        .last  (last_q),
        .grant (grant)
    );

    assign new_idx = grant[1];

    // ---------------- FSM: state register ----------------
    // NOTE: every clocked block uses non-blocking assignments so all registers
    // update from the same pre-edge values and simulation matches hardware.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rec_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rec_q   <= rec_d;
        end
    end

    // ---------------- FSM: next state ----------------
    // NOTE: each combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rec_d       = 1'b0;
        timeout_hit = 1'b0;
        case (state_q)
            IDLE:    if (|grant) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                // A strobe on the last allowed cycle still counts as success.
                if (mem_valid) begin
                    state_d = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = RESP;
                    timeout_hit = 1'b1;
                end
                if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
            end
            RESP:    state_d = RECOVER;
            RECOVER: begin
                // rec_q marks the second RECOVER cycle.
                rec_d = !rec_q;
                if (rec_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Decoded from the next state so the registered outputs line up with the
    // state they describe.
    always_comb begin
        mem_select_d = 1'b0;
        mem_op_d     = OP_READ;
        ack_d        = 2'b00;
        err_d        = 1'b0;
        rdata_d      = rdata_q;
        case (state_d)
            SETUP:  mem_select_d = 1'b1;
            ACCESS, WAIT: begin
                mem_select_d = 1'b1;
                mem_op_d     = we_q ? OP_WRITE : OP_READ;
            end
            RESP: begin
                mem_select_d = 1'b1;
                mem_op_d     = we_q ? OP_WRITE : OP_READ;
                ack_d        = last_q ? 2'b10 : 2'b01;
                err_d        = timeout_hit;
                // RESP is only entered from WAIT; timeouts and writes return 0.
                rdata_d      = (mem_valid && (we_q == OP_READ)) ? mem_rdata : '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q        <= 2'b00;
            err_q        <= 1'b0;
            rdata_q      <= '0;
            mem_select_q <= 1'b0;
            mem_op_q     <= OP_READ;
        end else begin
            ack_q        <= ack_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
            mem_select_q <= mem_select_d;
            mem_op_q     <= mem_op_d;
        end
    end

    // ---------------- Request capture at grant ----------------
    // last_q doubles as the index of the requester currently being served.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q      <= 1'b1;
            we_q        <= OP_READ;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else if ((state_q == IDLE) && (|grant)) begin
            last_q      <= new_idx;
            we_q        <= new_idx ? we[1] : we[0];
            mem_addr_q  <= new_idx ? addr[2*ADDR_W-1:ADDR_W] : addr[ADDR_W-1:0];
            mem_wdata_q <= new_idx ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];
        end
    end

    assign ack        = ack_q;
    assign err        = err_q;
    assign rdata      = rdata_q;
    assign mem_select = mem_select_q;
    assign mem_op     = mem_op_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_scheduler.sv
// Self-checking bench for mem_access_scheduler. A transaction-level reference
// model predicts the winner, ack cycle, err and rdata of each access from the
// arbitration and latency rules; outputs are sampled on the falling edge.
module tb_mem_access_scheduler;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int TO = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        req;
    logic [1:0]        we;
    logic [2*AW-1:0]   addr;
    logic [2*DW-1:0]   wdata;
    logic [1:0]        ack;
    logic              err;
    logic [DW-1:0]     rdata;
    logic              mem_select;
    logic              mem_op;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata;
    logic              mem_valid;

    int                vectors     = 0;
    int                miscompares = 0;

    // Reference model state
    int                last_m;      // requester granted most recently
    logic [DW-1:0]     prev_rdata;  // rdata value held since the last ack
    int                pre_next;    // cycles until the DUT can grant again

    always #5 clk = ~clk;

    mem_access_scheduler #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .we         (we),
        .addr       (addr),
        .wdata      (wdata),
        .ack        (ack),
        .err        (err),
        .rdata      (rdata),
        .mem_select (mem_select),
        .mem_op     (mem_op),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_valid  (mem_valid)
    );

    task automatic set_req(input int i, input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        req[i]            = 1'b1;
        we[i]             = w;
        addr[i*AW +: AW]  = a;
        wdata[i*DW +: DW] = d;
    endtask

    task automatic rand_req(input int i);
        set_req(i, 1'($urandom), AW'($urandom), DW'($urandom));
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        req       = 2'b00;
        we        = 2'b00;
        addr      = '0;
        wdata     = '0;
        mem_valid = 1'b0;
        mem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n      = 1'b1;
        last_m     = 1;
        prev_rdata = '0;
        pre_next   = 0;
    endtask

    // One complete access. d = WAIT cycles before mem_valid (d >= TO: never).
    // Edge k=0 is the grant edge; the ack is expected after edge lat.
    task automatic run_txn(input int d, input logic [DW-1:0] rval, input bit drop);
        int            w;
        int            lat;
        bit            to;
        logic          exp_we;
        logic [AW-1:0] exp_a;
        logic [DW-1:0] exp_wd;
        logic [DW-1:0] exp_rd;
        logic [1:0]    exp_ack;
        logic          exp_err;
        logic [DW-1:0] exp_rdata;

        if (req == 2'b11) w = (last_m == 1) ? 0 : 1;
        else              w = req[1] ? 1 : 0;
        last_m  = w;
        exp_we  = we[w];
        exp_a   = addr[w*AW +: AW];
        exp_wd  = wdata[w*DW +: DW];
        to      = (d >= TO);
        lat     = to ? (2 + TO) : (3 + d);
        exp_rd  = (exp_we || to) ? '0 : rval;

        // Leftover recovery edges; stray strobes here must be ignored.
        for (int p = 0; p < pre_next; p++) begin
            mem_valid = 1'($urandom);
            mem_rdata = DW'($urandom);
            @(posedge clk);
            @(negedge clk);
            vectors++;
            if (ack !== 2'b00) begin
                miscompares++;
                $display("FAIL pre_ack p=%0d: got %b expected 00", p, ack);
            end
        end

        for (int k = 0; k <= lat + 2; k++) begin
            if (k >= 3 && k <= lat) begin
                mem_valid = (!to && k == lat);
                mem_rdata = (k == lat) ? rval : DW'($urandom);
            end else begin
                mem_valid = 1'($urandom);
                mem_rdata = DW'($urandom);
            end
            @(posedge clk);
            @(negedge clk);

            exp_ack   = (k == lat) ? ((w == 1) ? 2'b10 : 2'b01) : 2'b00;
            exp_err   = (k == lat) && to;
            exp_rdata = (k >= lat) ? exp_rd : prev_rdata;

            vectors++;
            if (ack !== exp_ack) begin
                miscompares++;
                $display("FAIL ack k=%0d: got %b expected %b", k, ack, exp_ack);
            end
            vectors++;
            if (err !== exp_err) begin
                miscompares++;
                $display("FAIL err k=%0d: got %b expected %b", k, err, exp_err);
            end
            vectors++;
            if (rdata !== exp_rdata) begin
                miscompares++;
                $display("FAIL rdata k=%0d: got %h expected %h", k, rdata, exp_rdata);
            end
            if (k != lat) begin
                vectors++;
                if (mem_select !== (k < lat)) begin
                    miscompares++;
                    $display("FAIL mem_select k=%0d: got %b expected %b", k, mem_select, (k < lat));
                end
                vectors++;
                if (mem_op !== ((k >= 1 && k < lat) ? exp_we : 1'b0)) begin
                    miscompares++;
                    $display("FAIL mem_op k=%0d: got %b expected %b", k, mem_op,
                             ((k >= 1 && k < lat) ? exp_we : 1'b0));
                end
            end
            vectors++;
            if (mem_addr !== exp_a) begin
                miscompares++;
                $display("FAIL mem_addr k=%0d: got %h expected %h", k, mem_addr, exp_a);
            end
            vectors++;
            if (mem_wdata !== exp_wd) begin
                miscompares++;
                $display("FAIL mem_wdata k=%0d: got %h expected %h", k, mem_wdata, exp_wd);
            end

            // Withdrawing the request after the grant must not abort the access.
            if (drop && k == 0) req[w] = 1'b0;
        end
        mem_valid  = 1'b0;
        prev_rdata = exp_rd;
        pre_next   = 1;
    endtask

    task automatic test_reset();
        apply_reset();
        rst_n = 1'b0;
        #1;
        vectors++;
        if (ack !== 2'b00) begin miscompares++; $display("FAIL reset_ack: got %b expected 00", ack); end
        vectors++;
        if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b expected 0", err); end
        vectors++;
        if (rdata !== '0) begin miscompares++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
        vectors++;
        if (mem_select !== 1'b0) begin miscompares++; $display("FAIL reset_sel: got %b expected 0", mem_select); end
        vectors++;
        if (mem_op !== 1'b0) begin miscompares++; $display("FAIL reset_op: got %b expected 0", mem_op); end
        vectors++;
        if (mem_addr !== '0) begin miscompares++; $display("FAIL reset_addr: got %h expected 0", mem_addr); end
        vectors++;
        if (mem_wdata !== '0) begin miscompares++; $display("FAIL reset_wdata: got %h expected 0", mem_wdata); end
        apply_reset();
    endtask

    task automatic test_single_read();
        set_req(0, 1'b0, 4'd3, 8'h00);
        run_txn(0, 8'hA5, 1'b0);
        req = 2'b00;
    endtask

    task automatic test_timeout();
        set_req(0, 1'b1, 4'd9, 8'h3C);
        run_txn(TO, 8'h77, 1'b0);           // write, no strobe: err
        req = 2'b00;
        set_req(1, 1'b0, 4'd6, 8'h00);
        run_txn(TO - 1, 8'h5A, 1'b0);       // strobe on last allowed cycle
        req = 2'b00;
        set_req(1, 1'b0, 4'd2, 8'h00);
        run_txn(TO + 1, 8'hC3, 1'b0);       // read timeout returns 0
        req = 2'b00;
    endtask

    task automatic test_contention();
        apply_reset();
        rand_req(0);
        rand_req(1);
        for (int n = 0; n < 4; n++) begin
            run_txn(0, DW'($urandom), 1'b0);
            rand_req(last_m);               // served requester keeps requesting
        end
        req = 2'b00;
    endtask

    task automatic test_stray_valid();
        req = 2'b00;
        for (int c = 0; c < 4; c++) begin
            mem_valid = 1'b1;
            mem_rdata = DW'($urandom);
            @(posedge clk);
            @(negedge clk);
            vectors++;
            if (ack !== 2'b00) begin miscompares++; $display("FAIL stray_ack c=%0d: got %b expected 00", c, ack); end
            vectors++;
            if (rdata !== prev_rdata) begin
                miscompares++;
                $display("FAIL stray_rdata c=%0d: got %h expected %h", c, rdata, prev_rdata);
            end
        end
        mem_valid = 1'b0;
        pre_next  = 0;
        set_req(1, 1'b0, 4'd11, 8'h00);
        run_txn(2, 8'h96, 1'b0);
        req = 2'b00;
    endtask

    task automatic test_reset_in_wait();
        set_req(1, 1'b0, 4'd5, 8'h00);
        for (int p = 0; p < pre_next; p++) begin
            @(posedge clk);
            @(negedge clk);
        end
        mem_valid = 1'b0;
        repeat (4) begin                    // grant, SETUP, ACCESS, first WAIT
            @(posedge clk);
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (mem_select !== 1'b0) begin miscompares++; $display("FAIL rst_wait_sel: got %b expected 0", mem_select); end
        vectors++;
        if (ack !== 2'b00) begin miscompares++; $display("FAIL rst_wait_ack: got %b expected 00", ack); end
        vectors++;
        if (mem_addr !== '0) begin miscompares++; $display("FAIL rst_wait_addr: got %h expected 0", mem_addr); end
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (ack !== 2'b00) begin miscompares++; $display("FAIL rst_wait_ack2: got %b expected 00", ack); end
        rst_n      = 1'b1;
        last_m     = 1;
        prev_rdata = '0;
        pre_next   = 0;
        set_req(0, 1'b0, 4'd14, 8'h00);     // both requesting: 0 wins after reset
        run_txn(1, 8'h4B, 1'b0);
        req = 2'b00;
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic [1:0] rq;
            rq  = 2'($urandom_range(1, 3));
            req = 2'b00;
            if (rq[0]) rand_req(0);
            if (rq[1]) rand_req(1);
            run_txn(int'($urandom_range(0, TO + 1)), DW'($urandom), ($urandom_range(0, 3) == 0));
        end
        req = 2'b00;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_timeout();
        test_contention();
        test_stray_valid();
        test_reset_in_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/mem_access_scheduler.md
MEM_ACCESS_SCHEDULER -- requirements
Module: mem_access_scheduler

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, memory address width.
REQ-002 SHALL have parameter DATA_W, default 8, memory data width.
REQ-003 SHALL have parameter TIMEOUT, default 8, maximum cycles to wait for mem_valid.
REQ-004 SHALL have port clk  input  1  single system clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req  input  2  per-requester access request, level, held until ack.
REQ-007 SHALL have port we  input  2  per-requester direction, 1=write, 0=read.
REQ-008 SHALL have port addr  input  2*ADDR_W  per-requester address, requester i at [i*ADDR_W +: ADDR_W].
REQ-009 SHALL have port wdata  input  2*DATA_W  per-requester write data, same packing.
REQ-010 SHALL have port ack  output  2  one-cycle completion pulse per requester.
REQ-011 SHALL have port err  output  1  asserted with ack when the access timed out.
REQ-012 SHALL have port rdata  output  DATA_W  read data, valid in the ack cycle.
REQ-013 SHALL have port mem_select  output  1  cell-array select.
REQ-014 SHALL have port mem_op  output  1  cell-array operation, 1=write, 0=read.
REQ-015 SHALL have port mem_addr, mem_wdata  output  ADDR_W, DATA_W  registered copy of granted request.
REQ-016 SHALL have port mem_rdata  input  DATA_W  cell-array read data.
REQ-017 SHALL have port mem_valid  input  1  cell-array completion strobe.

Function
REQ-018 SHALL implement FSM states IDLE, SETUP, ACCESS, WAIT, RESP, RECOVER.
REQ-019 IDLE: if any req bit set, SHALL grant one requester round-robin, latch its we/addr/wdata, go to SETUP next cycle.
REQ-020 Round-robin: when both request, SHALL grant the requester not granted last; after reset requester 0 has priority.
REQ-021 SETUP: mem_select=1, mem_op=0, exactly one cycle, then ACCESS.
REQ-022 ACCESS: mem_select=1, mem_op=latched we, exactly one cycle, then WAIT; timeout counter cleared.
REQ-023 WAIT: mem_select=1, mem_op held; on mem_valid SHALL capture mem_rdata (reads only) and go to RESP; if the counter reaches TIMEOUT-1 without mem_valid SHALL set err flag and go to RESP.
REQ-024 mem_valid sampled outside WAIT SHALL be ignored.
REQ-025 RESP: ack[granted]=1 for exactly one cycle, err=timeout flag, rdata=captured value (0 on write or timeout); then RECOVER.
REQ-026 RECOVER: mem_select=0, mem_op=0 for exactly two cycles (returns cell array to known state), then IDLE.
REQ-027 Minimum request-to-ack latency SHALL be 4 cycles (grant, SETUP, ACCESS, WAIT with mem_valid in first WAIT cycle); ack-to-next-grant spacing 3 cycles.
REQ-028 A requester dropping req after grant SHALL NOT abort the access; ack still issued.
REQ-029 New requests arriving during SETUP..RECOVER SHALL wait; no queueing beyond the req level.
REQ-030 rdata SHALL hold its last value outside RESP; ack and err SHALL be 0 outside RESP.
REQ-031 Timeout counter SHALL be $clog2(TIMEOUT)+1 bits, saturating, never wrapping.

Reset
REQ-032 On rst_n=0, asynchronously: state=IDLE, ack=0, err=0, rdata=0, mem_select=0, mem_op=0, mem_addr=0, mem_wdata=0, last-grant=1, counter=0.
REQ-033 Reset mid-access SHALL drop the access with no ack; first cycle after release SHALL be IDLE.

Structure
REQ-034 State enum and op encoding (OP_READ=0, OP_WRITE=1) SHALL live in shared package mem_ctrl_pkg.
REQ-035 Round-robin selection SHALL be sub-module rr_arb2 (req[1:0], last, grant[1:0], one-hot or zero).
REQ-036 All outputs SHALL be registered; no combinational path from req to mem_*.

Verification
REQ-037 Single read: req=01, we=0, addr0=3, mem_valid in first WAIT cycle with mem_rdata=0xA5 -> ack=01 at cycle 4, rdata=0xA5, err=0.
REQ-038 Contention: req=11 held from reset -> grants 0,1,0,1 alternating; ack pulses 01,10,01,10 spaced 7 cycles.
REQ-039 Timeout: write, mem_valid never asserted, TIMEOUT=8 -> ack with err=1 after 8 WAIT cycles, rdata=0.
REQ-040 Sequence check: mem_select/mem_op = 1/0 (SETUP), 1/we (ACCESS), then 0/0 for exactly two cycles after ack.
REQ-041 Reset in WAIT: rst_n low one cycle -> mem_select=0 immediately, no ack, next access proceeds normally.
REQ-042 Stray mem_valid in IDLE and RECOVER -> no ack, state unchanged.
